// File: rtl/dp_bram_ctrl_if.sv
// dp_bram_ctrl_if
// Bus bundle for the dual-port block-RAM controller.
//   clr_req / busy              : clear-engine request and status
//   a_* / b_*                   : two identical RAM ports
//                                 (en, byte we, addr, din, dout, rvalid)
//   coll                        : same-address write/write collision pulse
// Modports: master drives requests (IP engine side), slave is the controller.
interface dp_bram_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12
) ();
    logic                  clr_req;
    logic                  busy;

    logic                  a_en;
    logic [DATA_W/8-1:0]   a_we;
    logic [ADDR_W-1:0]     a_addr;
    logic [DATA_W-1:0]     a_din;
    logic [DATA_W-1:0]     a_dout;
    logic                  a_rvalid;

    logic                  b_en;
    logic [DATA_W/8-1:0]   b_we;
    logic [ADDR_W-1:0]     b_addr;
    logic [DATA_W-1:0]     b_din;
    logic [DATA_W-1:0]     b_dout;
    logic                  b_rvalid;

    logic                  coll;

    modport master (
        output clr_req, a_en, a_we, a_addr, a_din, b_en, b_we, b_addr, b_din,
        input  busy, a_dout, a_rvalid, b_dout, b_rvalid, coll
    );

    modport slave (
        input  clr_req, a_en, a_we, a_addr, a_din, b_en, b_we, b_addr, b_din,
        output busy, a_dout, a_rvalid, b_dout, b_rvalid, coll
    );
endinterface

// File: rtl/dp_bram_ctrl.sv
// dp_bram_ctrl
// Single-clock true-dual-port block-RAM controller with byte write enables,
// RD_LAT (1 or 2) read pipeline with rvalid strobes, selectable cross-port
// write mode (WR_MODE 0 = read-first, 1 = write-first), port-A-priority
// write/write collision resolution and a zero-fill clear engine.
// Ports:
//   clk       : clock, rising edge
//   srst_q    : synchronous active-high reset
//   bus       : dp_bram_ctrl_if.slave (clear request/busy, ports A/B, coll)
//   coll_cnt  : saturating collision count, present only when the macro
//               BRAM_COLL_CNT_EN is defined
//
// Clear FSM
//   state | meaning
//   IDLE  | ports serve reads/writes normally
//   CLEAR | one word per cycle zeroed at clr_cnt_q, port accesses dropped
module dp_bram_ctrl #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 12,
    parameter int RD_LAT     = 1,
    parameter int WR_MODE    = 0,
    parameter int CLR_ON_RST = 0
) (
    input  logic          clk,
    input  logic          srst_q,
    dp_bram_ctrl_if.slave bus
`ifdef BRAM_COLL_CNT_EN
    ,
    output logic [15:0]   coll_cnt
`endif
);
    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic                rst_rel_q;
    logic                clr_start;
    logic                busy_w;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic                a_wr, a_rd, b_wr, b_rd;
    logic [DATA_W-1:0]   a_word, b_word;

    logic [DATA_W-1:0]   a_p1_d, b_p1_d, a_dout_q, b_dout_q;
    logic                a_p1_v, b_p1_v, a_rvalid_q, b_rvalid_q;
    logic                coll_q;

    // rst_rel_q is high for exactly the first cycle after reset release,
    // which is when an automatic sweep may be launched.
    always_ff @(posedge clk) begin
        if (srst_q) begin
            state_q   <= IDLE;
            clr_cnt_q <= '0;
            rst_rel_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            rst_rel_q <= 1'b0;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        clr_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.clr_req || ((CLR_ON_RST != 0) && rst_rel_q)) begin
                    clr_start = 1'b1;
                    state_d   = CLEAR;
                    clr_cnt_d = '0;
                end
            end
            CLEAR: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == '1)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_w = (state_q == CLEAR);

    assign a_wr = bus.a_en &&  (|bus.a_we) && !busy_w;
    assign a_rd = bus.a_en && !(|bus.a_we) && !busy_w;
    assign b_wr = bus.b_en &&  (|bus.b_we) && !busy_w;
    assign b_rd = bus.b_en && !(|bus.b_we) && !busy_w;

    // Write-first mode forwards the other port's same-cycle write bytes
    // into the read word; read-first just takes the stored word.
    always_comb begin
        a_word = mem[bus.a_addr];
        b_word = mem[bus.b_addr];
        if (WR_MODE != 0) begin
            for (int i = 0; i < NB; i++) begin
                if (b_wr && (bus.b_addr == bus.a_addr) && bus.b_we[i])
                    a_word[i*8 +: 8] = bus.b_din[i*8 +: 8];
                if (a_wr && (bus.a_addr == bus.b_addr) && bus.a_we[i])
                    b_word[i*8 +: 8] = bus.a_din[i*8 +: 8];
            end
        end
    end

    // Port A bytes are assigned last so they win on overlapping bytes.
    // The sweep write is suppressed on a reset edge so a mid-sweep reset
    // leaves not-yet-cleared words untouched.
    always_ff @(posedge clk) begin
        if (busy_w) begin
            if (!srst_q)
                mem[clr_cnt_q] <= '0;
        end else begin
            for (int i = 0; i < NB; i++)
                if (b_wr && bus.b_we[i])
                    mem[bus.b_addr][i*8 +: 8] <= bus.b_din[i*8 +: 8];
            for (int i = 0; i < NB; i++)
                if (a_wr && bus.a_we[i])
                    mem[bus.a_addr][i*8 +: 8] <= bus.a_din[i*8 +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (srst_q) begin
            a_p1_v     <= 1'b0;
            b_p1_v     <= 1'b0;
            a_p1_d     <= '0;
            b_p1_d     <= '0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_dout_q   <= '0;
            b_dout_q   <= '0;
            coll_q     <= 1'b0;
        end else begin
            a_p1_v <= a_rd;
            b_p1_v <= b_rd;
            a_p1_d <= a_word;
            b_p1_d <= b_word;
            if (RD_LAT == 1) begin
                a_rvalid_q <= a_rd;
                b_rvalid_q <= b_rd;
                if (a_rd) a_dout_q <= a_word;
                if (b_rd) b_dout_q <= b_word;
            end else begin
                a_rvalid_q <= a_p1_v;
                b_rvalid_q <= b_p1_v;
                if (a_p1_v) a_dout_q <= a_p1_d;
                if (b_p1_v) b_dout_q <= b_p1_d;
            end
            coll_q <= a_wr && b_wr && (bus.a_addr == bus.b_addr) &&
                      (|(bus.a_we & bus.b_we));
        end
    end

`ifdef BRAM_COLL_CNT_EN
    always_ff @(posedge clk) begin
        if (srst_q || clr_start)
            coll_cnt <= '0;
        else if (coll_q && (coll_cnt != 16'hFFFF))
            coll_cnt <= coll_cnt + 16'd1;
    end
`endif

    assign bus.busy     = busy_w;
    assign bus.a_dout   = a_dout_q;
    assign bus.a_rvalid = a_rvalid_q;
    assign bus.b_dout   = b_dout_q;
    assign bus.b_rvalid = b_rvalid_q;
    assign bus.coll     = coll_q;
endmodule

// File: tb/tb_dp_bram_ctrl.sv
module tb_dp_bram_ctrl;
    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 12;
    localparam int RD_LAT  = 1;
    localparam int WR_MODE = 0;
    localparam int DEPTH   = 4096;

    logic clk = 1'b0;
    logic srst_q;
    always #5 clk = ~clk;

    dp_bram_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();
`ifdef BRAM_COLL_CNT_EN
    logic [15:0] coll_cnt;
`endif

    dp_bram_ctrl #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT),
        .WR_MODE(WR_MODE), .CLR_ON_RST(0)
    ) dut (
        .clk(clk),
        .srst_q(srst_q),
        .bus(bus)
`ifdef BRAM_COLL_CNT_EN
        ,
        .coll_cnt(coll_cnt)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: word array, sweep bookkeeping, read results keyed by
    // the cycle on which they must be visible.
    logic [31:0] ref_mem [DEPTH];
    int          clr_left = 0;
    int          clr_addr = 0;
    bit          exp_av [int];
    bit          exp_bv [int];
    logic [31:0] exp_ad [int];
    logic [31:0] exp_bd [int];
    logic [31:0] exp_a_dout, exp_b_dout;
    bit          exp_a_rv, exp_b_rv, exp_coll, exp_busy;
    logic [15:0] exp_cnt;

    task automatic step();
        bit drop, aw, ar, bw, br, coll_now;
        logic [31:0] aword, bword;
        int n;
        n = cyc + 1;
        if (srst_q) begin
            clr_left = 0;
            exp_av.delete(); exp_bv.delete(); exp_ad.delete(); exp_bd.delete();
            exp_a_dout = 0; exp_b_dout = 0; exp_coll = 0; exp_cnt = 0;
        end else begin
            drop  = (clr_left > 0);
            aw    = bus.a_en && (bus.a_we != 0) && !drop;
            ar    = bus.a_en && (bus.a_we == 0) && !drop;
            bw    = bus.b_en && (bus.b_we != 0) && !drop;
            br    = bus.b_en && (bus.b_we == 0) && !drop;
            aword = ref_mem[bus.a_addr];
            bword = ref_mem[bus.b_addr];
            if (WR_MODE == 1) begin
                for (int i = 0; i < 4; i++) begin
                    if (bw && bus.b_addr == bus.a_addr && bus.b_we[i]) aword[i*8 +: 8] = bus.b_din[i*8 +: 8];
                    if (aw && bus.a_addr == bus.b_addr && bus.a_we[i]) bword[i*8 +: 8] = bus.a_din[i*8 +: 8];
                end
            end
            if (ar) begin exp_av[n+RD_LAT-1] = 1; exp_ad[n+RD_LAT-1] = aword; end
            if (br) begin exp_bv[n+RD_LAT-1] = 1; exp_bd[n+RD_LAT-1] = bword; end
            coll_now = aw && bw && (bus.a_addr == bus.b_addr) && ((bus.a_we & bus.b_we) != 0);
            if (!drop && bus.clr_req) exp_cnt = 0;
            else if (exp_coll && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 1;
            if (drop) begin
                ref_mem[clr_addr] = 0; clr_addr++; clr_left--;
            end else begin
                for (int i = 0; i < 4; i++) if (bw && bus.b_we[i]) ref_mem[bus.b_addr][i*8 +: 8] = bus.b_din[i*8 +: 8];
                for (int i = 0; i < 4; i++) if (aw && bus.a_we[i]) ref_mem[bus.a_addr][i*8 +: 8] = bus.a_din[i*8 +: 8];
                if (bus.clr_req) begin clr_left = DEPTH; clr_addr = 0; end
            end
            exp_coll = coll_now;
        end
        @(posedge clk); #1;
        cyc = n;
        exp_busy = (clr_left > 0);
        exp_a_rv = exp_av.exists(cyc);
        if (exp_a_rv) begin exp_a_dout = exp_ad[cyc]; exp_av.delete(cyc); exp_ad.delete(cyc); end
        exp_b_rv = exp_bv.exists(cyc);
        if (exp_b_rv) begin exp_b_dout = exp_bd[cyc]; exp_bv.delete(cyc); exp_bd.delete(cyc); end
    endtask

    task automatic drive(input bit ae, input logic [3:0] awe, input logic [11:0] aa, input logic [31:0] ad,
                         input bit be, input logic [3:0] bwe, input logic [11:0] ba, input logic [31:0] bd);
        bus.a_en = ae; bus.a_we = awe; bus.a_addr = aa; bus.a_din = ad;
        bus.b_en = be; bus.b_we = bwe; bus.b_addr = ba; bus.b_din = bd;
        step();
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 4'h0, 12'h0, 32'h0, 0, 4'h0, 12'h0, 32'h0);
    endtask

    task automatic read_b(input logic [11:0] addr, output logic [31:0] d, output bit rv);
        drive(0, 4'h0, 12'h0, 32'h0, 1, 4'h0, addr, 32'h0);
        idle(RD_LAT - 1);
        d  = bus.b_dout;
        rv = bus.b_rvalid;
    endtask

    task automatic test_reset();
        srst_q = 1'b1; bus.clr_req = 1'b0;
        idle(3);
        n_checks++; if (bus.a_dout !== 32'h0) begin n_fail++; $display("FAIL reset_a_dout: got %h want 0", bus.a_dout); end
        n_checks++; if (bus.b_dout !== 32'h0) begin n_fail++; $display("FAIL reset_b_dout: got %h want 0", bus.b_dout); end
        n_checks++; if ({bus.a_rvalid, bus.b_rvalid, bus.coll, bus.busy} !== 4'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b want 0000", {bus.a_rvalid, bus.b_rvalid, bus.coll, bus.busy}); end
`ifdef BRAM_COLL_CNT_EN
        n_checks++; if (coll_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_coll_cnt: got %h want 0", coll_cnt); end
`endif
        srst_q = 1'b0;
        idle(1);
    endtask

    task automatic test_defaults();
        logic [11:0] addrs [3];
        int j;
        addrs[0] = 12'h010; addrs[1] = 12'h100; addrs[2] = 12'hFFF;
        for (int k = 0; k < 3; k++) drive(1, 4'hF, addrs[k], k + 1, 0, 4'h0, 12'h0, 32'h0);
        for (int k = 0; k < 3 + RD_LAT; k++) begin
            if (k < 3) drive(0, 4'h0, 12'h0, 32'h0, 1, 4'h0, addrs[k], 32'h0);
            else idle(1);
            j = k - (RD_LAT - 1);
            n_checks++; if (bus.a_rvalid !== 1'b0) begin n_fail++; $display("FAIL defaults_a_rvalid: got %b want 0", bus.a_rvalid); end
            if (j >= 0 && j < 3) begin
                n_checks++; if (bus.b_rvalid !== 1'b1) begin n_fail++; $display("FAIL defaults_b_rvalid[%0d]: got %b want 1", j, bus.b_rvalid); end
                n_checks++; if (bus.b_dout !== j + 1) begin n_fail++; $display("FAIL defaults_b_dout[%0d]: got %h want %h", j, bus.b_dout, j + 1); end
            end else begin
                n_checks++; if (bus.b_rvalid !== 1'b0) begin n_fail++; $display("FAIL defaults_b_rvalid_idle[%0d]: got %b want 0", k, bus.b_rvalid); end
                if (j >= 3) begin
                    n_checks++; if (bus.b_dout !== 32'd3) begin n_fail++; $display("FAIL defaults_b_dout_hold: got %h want 3", bus.b_dout); end
                end
            end
        end
    endtask

    task automatic test_byte_en();
        logic [31:0] d; bit rv;
        drive(1, 4'hF, 12'h020, 32'hAABBCCDD, 0, 4'h0, 12'h0, 32'h0);
        drive(1, 4'h2, 12'h020, 32'h00001100, 0, 4'h0, 12'h0, 32'h0);
        read_b(12'h020, d, rv);
        n_checks++; if (d !== 32'hAABB11DD || rv !== 1'b1) begin n_fail++; $display("FAIL byte_en: got %h/%b want aabb11dd/1", d, rv); end
    endtask

    task automatic test_collision();
        logic [31:0] d; bit rv;
        drive(1, 4'hF, 12'h030, 32'h11111111, 1, 4'h3, 12'h030, 32'h22222222);
        n_checks++; if (bus.coll !== 1'b1) begin n_fail++; $display("FAIL coll_pulse: got %b want 1", bus.coll); end
        idle(1);
        n_checks++; if (bus.coll !== 1'b0) begin n_fail++; $display("FAIL coll_one_cycle: got %b want 0", bus.coll); end
        read_b(12'h030, d, rv);
        n_checks++; if (d !== 32'h11111111) begin n_fail++; $display("FAIL coll_data_overlap: got %h want 11111111", d); end
        drive(1, 4'h3, 12'h030, 32'h11111111, 1, 4'hC, 12'h030, 32'h22222222);
        n_checks++; if (bus.coll !== 1'b0) begin n_fail++; $display("FAIL coll_disjoint: got %b want 0", bus.coll); end
        read_b(12'h030, d, rv);
        n_checks++; if (d !== 32'h22221111) begin n_fail++; $display("FAIL coll_data_disjoint: got %h want 22221111", d); end
    endtask

    task automatic test_cross_port();
        logic [31:0] d, want; bit rv;
        want = (WR_MODE == 1) ? 32'd9 : 32'd5;
        drive(1, 4'hF, 12'h040, 32'd5, 0, 4'h0, 12'h0, 32'h0);
        drive(1, 4'hF, 12'h040, 32'd9, 1, 4'h0, 12'h040, 32'h0);
        idle(RD_LAT - 1);
        n_checks++; if (bus.b_dout !== want || bus.b_rvalid !== 1'b1) begin
            n_fail++; $display("FAIL cross_port_same_cycle: got %h/%b want %h/1", bus.b_dout, bus.b_rvalid, want); end
        read_b(12'h040, d, rv);
        n_checks++; if (d !== 32'd9) begin n_fail++; $display("FAIL cross_port_later: got %h want 9", d); end
    endtask

    task automatic test_clear();
        logic [31:0] d; bit rv, rv_seen;
        int busy_cnt, guard;
        drive(1, 4'hF, 12'h000, 32'd7, 1, 4'hF, 12'hFFF, 32'd7);
        bus.clr_req = 1'b1; idle(1); bus.clr_req = 1'b0;
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL clear_busy_start: got %b want 1", bus.busy); end
        busy_cnt = 0; guard = 0; rv_seen = 0;
        while (bus.busy === 1'b1 && guard < 5000) begin
            busy_cnt++; guard++;
            if (bus.a_rvalid || bus.b_rvalid) rv_seen = 1;
            if (guard == 10) drive(1, 4'hF, 12'h050, 32'h0000DEAD, 1, 4'h0, 12'h050, 32'h0);
            else if (guard == 20) begin bus.clr_req = 1'b1; idle(1); bus.clr_req = 1'b0; end
            else idle(1);
        end
        n_checks++; if (busy_cnt !== 4096) begin n_fail++; $display("FAIL clear_busy_len: got %0d want 4096", busy_cnt); end
        n_checks++; if (rv_seen !== 1'b0) begin n_fail++; $display("FAIL clear_rvalid_dropped: got %b want 0", rv_seen); end
        read_b(12'h000, d, rv);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL clear_word_000: got %h want 0", d); end
        read_b(12'h050, d, rv);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL clear_word_050: got %h want 0", d); end
        read_b(12'hFFF, d, rv);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL clear_word_fff: got %h want 0", d); end
    endtask

    task automatic test_reset_mid_sweep();
        logic [31:0] d; bit rv;
        drive(1, 4'hF, 12'h002, 32'd7, 1, 4'hF, 12'hFFF, 32'd7);
        bus.clr_req = 1'b1; idle(1); bus.clr_req = 1'b0;
        idle(99);
        srst_q = 1'b1; idle(1);
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midsweep_busy: got %b want 0", bus.busy); end
        srst_q = 1'b0; idle(2);
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midsweep_no_restart: got %b want 0", bus.busy); end
        read_b(12'h002, d, rv);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL midsweep_cleared: got %h want 0", d); end
        read_b(12'hFFF, d, rv);
        n_checks++; if (d !== 32'd7) begin n_fail++; $display("FAIL midsweep_untouched: got %h want 7", d); end
    endtask

    task automatic test_random();
        bit ae, be;
        logic [3:0] awe, bwe;
        for (int k = 0; k < 8; k++) drive(1, 4'hF, 12'h3C0 + k, $urandom, 0, 4'h0, 12'h0, 32'h0);
        for (int k = 0; k < 400; k++) begin
            ae  = ($urandom_range(0, 3) != 0);
            be  = ($urandom_range(0, 3) != 0);
            awe = $urandom_range(0, 1) ? 4'($urandom_range(1, 15)) : 4'h0;
            bwe = $urandom_range(0, 1) ? 4'($urandom_range(1, 15)) : 4'h0;
            drive(ae, awe, 12'h3C0 + 12'($urandom_range(0, 3)), $urandom,
                  be, bwe, 12'h3C0 + 12'($urandom_range(0, 3)), $urandom);
            n_checks++; if (bus.a_rvalid !== exp_a_rv || bus.a_dout !== exp_a_dout) begin
                n_fail++; $display("FAIL rand_a[%0d]: got %b/%h want %b/%h", k, bus.a_rvalid, bus.a_dout, exp_a_rv, exp_a_dout); end
            n_checks++; if (bus.b_rvalid !== exp_b_rv || bus.b_dout !== exp_b_dout) begin
                n_fail++; $display("FAIL rand_b[%0d]: got %b/%h want %b/%h", k, bus.b_rvalid, bus.b_dout, exp_b_rv, exp_b_dout); end
            n_checks++; if (bus.coll !== exp_coll || bus.busy !== exp_busy) begin
                n_fail++; $display("FAIL rand_coll_busy[%0d]: got %b%b want %b%b", k, bus.coll, bus.busy, exp_coll, exp_busy); end
`ifdef BRAM_COLL_CNT_EN
            n_checks++; if (coll_cnt !== exp_cnt) begin n_fail++; $display("FAIL rand_coll_cnt[%0d]: got %h want %h", k, coll_cnt, exp_cnt); end
`endif
        end
    endtask

`ifdef BRAM_COLL_CNT_EN
    task automatic test_coll_cnt();
        int guard;
        srst_q = 1'b1; idle(1); srst_q = 1'b0;
        repeat (3) drive(1, 4'hF, 12'h030, 32'h1, 1, 4'h1, 12'h030, 32'h2);
        idle(2);
        n_checks++; if (coll_cnt !== 16'd3) begin n_fail++; $display("FAIL coll_cnt_three: got %0d want 3", coll_cnt); end
        bus.clr_req = 1'b1; idle(1); bus.clr_req = 1'b0;
        n_checks++; if (coll_cnt !== 16'd0) begin n_fail++; $display("FAIL coll_cnt_clear: got %0d want 0", coll_cnt); end
        guard = 0;
        while (bus.busy === 1'b1 && guard < 5000) begin guard++; idle(1); end
        n_checks++; if (guard >= 5000) begin n_fail++; $display("FAIL coll_cnt_sweep_end: got busy after %0d cycles want idle", guard); end
    endtask
`endif

    initial begin
        srst_q = 1'b1;
        bus.clr_req = 1'b0;
        bus.a_en = 0; bus.a_we = 0; bus.a_addr = 0; bus.a_din = 0;
        bus.b_en = 0; bus.b_we = 0; bus.b_addr = 0; bus.b_din = 0;
        test_reset();
        test_defaults();
        test_byte_en();
        test_collision();
        test_cross_port();
        test_random();
        test_clear();
        test_reset_mid_sweep();
`ifdef BRAM_COLL_CNT_EN
        test_coll_cnt();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dp_bram_ctrl.md
Name: dp_bram_ctrl

Overview:
- Parametrised single-clock true-dual-port block-RAM controller. Successor to the fixed 12-bit-address, 32-bit-data, two-port memory wrapper.
- Adds byte write enables, configurable read latency with read-valid strobes, selectable cross-port write mode and defined same-address collision resolution.
- Adds a hardware clear engine that sweeps the array to zero.
- Sits between CNN IP engines and on-chip buffers (feature maps, weights).

Parameters:
- DATA_W, 32, word width; must be a multiple of 8.
- ADDR_W, 12, address width; depth = 2**ADDR_W words.
- RD_LAT, 1, read latency in cycles; legal values 1 or 2.
- WR_MODE, 0, cross-port read of a word written in the same cycle: 0 = read-first (old data), 1 = write-first (new merged data).
- CLR_ON_RST, 0, 1 = start a clear sweep automatically on reset release.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- srst_q  in  1  synchronous, active-high reset.
- clr_req  in  1  one-cycle request to zero the whole array.
- busy  out  1  clear sweep in progress.
- a_en  in  1  port A access enable.
- a_we  in  DATA_W/8  port A byte write enables; any bit set makes the access a write.
- a_addr  in  ADDR_W  port A address.
- a_din  in  DATA_W  port A write data.
- a_dout  out  DATA_W  port A read data.
- a_rvalid  out  1  port A read data valid.
- b_en, b_we, b_addr, b_din, b_dout, b_rvalid: port B, identical to port A.
- coll  out  1  one-cycle pulse on a same-address write/write collision.

Behaviour:
- Reset: a_dout and b_dout = 0; a_rvalid, b_rvalid, coll and busy = 0; FSM goes to IDLE; clear counter = 0. Memory contents are not reset.
- Clock and reset are fixed: one clock `clk`; reset `srst_q` is synchronous and active-high.
- Access type:
  - en=1 with we=0 is a read.
  - en=1 with we≠0 writes only the enabled bytes.
  - en=0 means no access.
- Read timing:
  - Data and rvalid appear exactly RD_LAT cycles after the read is sampled.
  - rvalid is high for one cycle per read; back-to-back reads give one result per cycle.
  - dout holds its last value when rvalid=0.
  - Writes never assert rvalid and never update the writing port's dout.
- Cross-port read/write, same address, same cycle: the reading port returns the pre-write word (WR_MODE=0) or the byte-merged new word (WR_MODE=1).
- Write/write collision, same address, same cycle:
  - Bytes enabled on both ports take port A data.
  - Bytes enabled on only one port take that port's data.
  - coll pulses one cycle later, only if at least one byte overlaps.
- Read/read to the same address: both ports return the word; no coll.
- Clear FSM, states IDLE and CLEAR:
  - IDLE→CLEAR on clr_req=1, or on the first cycle after reset release when CLR_ON_RST=1.
  - In CLEAR, one word per cycle at counter address 0..2**ADDR_W-1 is written with zeros.
  - On the last address the FSM returns to IDLE. The sweep takes exactly 2**ADDR_W cycles.
  - busy=1 while in CLEAR and goes low the cycle after the last address is written.
  - clr_req during CLEAR is ignored.
  - In CLEAR, port accesses are dropped: no write and no rvalid. Reads already issued still complete in their pipeline.
- Reset mid-sweep: the FSM goes to IDLE and busy=0 on the next edge. Already-cleared words stay zero; the rest are unchanged. If CLR_ON_RST=1, the sweep restarts from address 0.
- Address wrap: no wrap logic; the full 2**ADDR_W range is valid.

Optional Feature:
- Macro BRAM_COLL_CNT_EN.
- Defined:
  - Adds output coll_cnt[15:0], a saturating count of coll pulses (stays at 0xFFFF).
  - Cleared by srst_q and at the start of a clear sweep.
- Undefined: port and counter are absent; coll is still present.

Test Plan:
- Defaults. A writes 1 to 0x010, 2 to 0x100, 3 to 0xFFF; B then reads each in successive cycles -> b_dout 1, 2, 3, with b_rvalid high one cycle after each read; a_rvalid stays 0.
- Byte enables. Write 0xAABBCCDD to 0x020 with we=4'b1111; write 0x00001100 with we=4'b0010; read -> 0xAABB11DD.
- Collision at 0x030, same cycle:
  - A we=1111 din 0x11111111, B we=0011 din 0x22222222 -> coll pulse, read 0x11111111.
  - Repeat with A we=0011, B we=1100 -> no coll, read 0x22221111.
- Cross-port. 0x040 holds 5; A writes 9 while B reads 0x040 in the same cycle -> b_dout = 5 with WR_MODE=0, 9 with WR_MODE=1; a later read returns 9 in both modes.
- Clear:
  - Fill 0x000/0xFFF with 7, pulse clr_req -> busy for 4096 cycles; A write of 0xDEAD to 0x050 during busy is dropped; reads of 0x000, 0x050 and 0xFFF return 0.
  - Assert srst_q at sweep cycle 100 -> busy=0 next cycle, 0xFFF still reads 7.
- RD_LAT=2 with BRAM_COLL_CNT_EN defined. Consecutive reads -> data two cycles after issue, with no gaps. Three overlapping collisions -> coll_cnt = 3.
